// File: rtl/toggle_pkg.sv
// Shared types for the debounced toggle-command generator.
package toggle_pkg;
    localparam int PCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;
endpackage

// File: rtl/btn_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module btn_sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule

// File: rtl/toggle_cmd_gen.sv
// Debounced push-button to single-cycle T strobe generator.
// Optional auto-repeat while held: define TOGGLE_AUTOREPEAT_EN.
module toggle_cmd_gen
    import toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int REPEAT_DELAY    = 200,
    parameter int REPEAT_PERIOD   = 50
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_in,
    input  logic              en,
    output logic              t,
    output logic              busy,
    output logic [PCNT_W-1:0] press_cnt
);
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_db
        $error("toggle_cmd_gen: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
        $error("toggle_cmd_gen: repeat delay/period must be >= 1");
    end

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              w_btn_s;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_strobe;
    logic              r_t;
    logic [PCNT_W-1:0] r_pcnt;

    btn_sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_in),
        .q       (w_btn_s)
    );

`ifdef TOGGLE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] LP_REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] LP_REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] r_rep;
    logic             r_rep_first;
    logic             w_rep_hit;

    assign w_rep_hit = (r_rep == (r_rep_first ? LP_REP_FIRST : LP_REP_NEXT));

    // Counter only advances while staying in HELD; any other path restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rep       <= '0;
            r_rep_first <= 1'b1;
        end else if (r_state == HELD && w_state_nxt == HELD) begin
            if (w_rep_hit) begin
                r_rep       <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep <= r_rep + 1'b1;
            end
        end else begin
            r_rep       <= '0;
            r_rep_first <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_strobe    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESS_DB;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_strobe    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = RELEASE_DB;
                    w_cnt_nxt   = '0;
                end else begin
`ifdef TOGGLE_AUTOREPEAT_EN
                    w_strobe = w_rep_hit;
`endif
                end
            end
            RELEASE_DB: begin
                // A bounce back high resumes HELD without a new strobe.
                if (w_btn_s) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t    <= 1'b0;
            r_pcnt <= '0;
        end else begin
            r_t <= w_strobe & en;
            if (w_strobe && en) begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    assign t         = r_t;
    assign busy      = (r_state != IDLE);
    assign press_cnt = r_pcnt;
endmodule

// File: tb/tb_toggle_cmd_gen.sv
// Self-checking bench for toggle_cmd_gen against a run-length reference model.
// Auto-repeat scenario is exercised when TOGGLE_AUTOREPEAT_EN is defined.
module tb_toggle_cmd_gen;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_in;
    logic       en;
    logic       t;
    logic       busy;
    logic [7:0] press_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    toggle_cmd_gen #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (5),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_in    (btn_in),
        .en        (en),
        .t         (t),
        .busy      (busy),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a press is accepted after D+1 consecutive high synchronised
    // samples, a release after D+1 consecutive low ones.
    bit       m_s1 = 0, m_s2 = 0, m_pressed = 0, m_t = 0, m_busy = 0;
    int       m_ones = 0, m_zeros = 0, m_ht = 0;
    bit [7:0] m_cnt = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; m_pressed = 0; m_t = 0; m_busy = 0;
            m_ones = 0; m_zeros = 0; m_ht = 0; m_cnt = 0;
        end else begin
            bit s, fire;
            s = m_s2; fire = 0;
            if (!m_pressed) begin
                if (s) m_ones++; else m_ones = 0;
                if (m_ones == D + 1) begin
                    m_pressed = 1; m_ones = 0; m_zeros = 0; m_ht = 0; fire = 1;
                end
            end else if (s) begin
                if (m_zeros > 0) begin
                    m_zeros = 0; m_ht = 0;
                end else begin
                    m_ht++;
`ifdef TOGGLE_AUTOREPEAT_EN
                    if (m_ht == RD || (m_ht > RD && (m_ht - RD) % RP == 0)) fire = 1;
`endif
                end
            end else begin
                m_zeros++; m_ht = 0;
                if (m_zeros == D + 1) begin
                    m_pressed = 0; m_zeros = 0;
                end
            end
            m_t = fire && en;
            if (m_t) m_cnt++;
            m_busy = m_pressed || (m_ones > 0);
            m_s2 = m_s1; m_s1 = btn_in;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; btn_in = 0; en = 1;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0; btn_in = 0; en = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({t, busy, press_cnt} !== 10'b0) begin
            errors++;
            $display("FAIL reset: t/busy/cnt got %b/%b/%0d want 0/0/0", t, busy, press_cnt);
        end
        reset_n = 1;
    endtask

    task automatic test_clean_press();
        int k, rise, brise, pulses;
        rise = -1; brise = -1; pulses = 0;
        for (int i = 0; i < 52; i++) begin
            btn_in = (i < 40);
            if (i == 0) k = cyc + 1;
            @(negedge clk);
            checks++;
            if ({t, busy, press_cnt} !== {m_t, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL clean_model: t/busy/cnt got %b/%b/%0d want %b/%b/%0d", t, busy, press_cnt, m_t, m_busy, m_cnt);
            end
            if (t) begin pulses++; if (rise < 0) rise = cyc; end
            if (busy && brise < 0) brise = cyc;
        end
        checks++;
        if (rise != k + D + 2 || pulses != 1) begin
            errors++;
            $display("FAIL clean_timing: rise edge %0d pulses %0d want edge %0d pulses 1", rise, pulses, k + D + 2);
        end
        checks++;
        if (brise != k + 2 || press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clean_busy_cnt: busy edge %0d cnt %0d want edge %0d cnt 1", brise, press_cnt, k + 2);
        end
    endtask

    task automatic test_bounce();
        int lr, rise, pulses;
        bit lvl, prev;
        lr = -1; rise = -1; pulses = 0; prev = 0;
        for (int i = 0; i < 44; i++) begin
            lvl = (i < 12) ? ((i / 2) % 2 == 0) : (i < 32);
            if (lvl && !prev) lr = cyc + 1;
            prev = lvl;
            btn_in = lvl;
            @(negedge clk);
            checks++;
            if ({t, busy, press_cnt} !== {m_t, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL bounce_model: t/busy/cnt got %b/%b/%0d want %b/%b/%0d", t, busy, press_cnt, m_t, m_busy, m_cnt);
            end
            if (t) begin pulses++; rise = cyc; end
        end
        checks++;
        if (pulses != 1 || rise != lr + D + 2 || press_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bounce: pulses %0d edge %0d cnt %0d want 1 %0d 2", pulses, rise, press_cnt, lr + D + 2);
        end
    endtask

    task automatic test_release_bounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 36; i++) begin
            btn_in = (i < 12) || (i >= 14 && i < 24);
            @(negedge clk);
            checks++;
            if ({t, busy, press_cnt} !== {m_t, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL relbounce_model: t/busy/cnt got %b/%b/%0d want %b/%b/%0d", t, busy, press_cnt, m_t, m_busy, m_cnt);
            end
            if (t) pulses++;
        end
        checks++;
        if (pulses != 1 || press_cnt !== 8'd3) begin
            errors++;
            $display("FAIL relbounce: pulses %0d cnt %0d want 1 3", pulses, press_cnt);
        end
    endtask

    task automatic test_en_gate();
        int p0, p1;
        p0 = 0; p1 = 0;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            en = (i >= 24);
            btn_in = ((i % 24) < 12);
            @(negedge clk);
            checks++;
            if ({t, busy, press_cnt} !== {m_t, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL en_model: t/busy/cnt got %b/%b/%0d want %b/%b/%0d", t, busy, press_cnt, m_t, m_busy, m_cnt);
            end
            if (t) begin if (i < 24) p0++; else p1++; end
            if (i == 23) begin
                checks++;
                if (p0 != 0 || press_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL en_off: pulses %0d cnt %0d want 0 0", p0, press_cnt);
                end
            end
        end
        checks++;
        if (p1 != 1 || press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL en_on: pulses %0d cnt %0d want 1 1", p1, press_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int k2, rise, pulses;
        rise = -1; pulses = 0;
        for (int i = 0; i < 4; i++) begin
            btn_in = 1;
            @(negedge clk);
        end
        reset_n = 0;
        #1;
        checks++;
        if ({t, busy, press_cnt} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid: t/busy/cnt got %b/%b/%0d want 0/0/0", t, busy, press_cnt);
        end
        repeat (2) @(negedge clk);
        reset_n = 1;
        k2 = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            btn_in = (i < 12);
            @(negedge clk);
            checks++;
            if ({t, busy, press_cnt} !== {m_t, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL reset_mid_model: t/busy/cnt got %b/%b/%0d want %b/%b/%0d", t, busy, press_cnt, m_t, m_busy, m_cnt);
            end
            if (t) begin pulses++; if (rise < 0) rise = cyc; end
        end
        checks++;
        if (pulses != 1 || rise != k2 + D + 2) begin
            errors++;
            $display("FAIL reset_mid_press: pulses %0d edge %0d want 1 %0d", pulses, rise, k2 + D + 2);
        end
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 256 * 16; i++) begin
            btn_in = ((i % 16) < 8);
            @(negedge clk);
            checks++;
            if ({t, busy, press_cnt} !== {m_t, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL wrap_model: t/busy/cnt got %b/%b/%0d want %b/%b/%0d", t, busy, press_cnt, m_t, m_busy, m_cnt);
            end
            if (t) pulses++;
        end
        checks++;
        if (pulses != 256 || press_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap: pulses %0d cnt %0d want 256 0", pulses, press_cnt);
        end
    endtask

    task automatic test_random();
        int run;
        bit lvl;
        run = 0; lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                lvl = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 12);
                en  = ($urandom_range(0, 9) != 0);
            end
            btn_in = lvl;
            run--;
            @(negedge clk);
            checks++;
            if ({t, busy, press_cnt} !== {m_t, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL random_model @%0d: t/busy/cnt got %b/%b/%0d want %b/%b/%0d", cyc, t, busy, press_cnt, m_t, m_busy, m_cnt);
            end
        end
        en = 1;
    endtask

`ifdef TOGGLE_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 90; i++) begin
            btn_in = (i < 69);
            @(negedge clk);
            checks++;
            if ({t, busy, press_cnt} !== {m_t, m_busy, m_cnt}) begin
                errors++;
                $display("FAIL repeat_model: t/busy/cnt got %b/%b/%0d want %b/%b/%0d", t, busy, press_cnt, m_t, m_busy, m_cnt);
            end
            if (t) pulses++;
        end
        checks++;
        if (pulses != 6 || press_cnt !== 8'd6) begin
            errors++;
            $display("FAIL repeat: pulses %0d cnt %0d want 6 6", pulses, press_cnt);
        end
    endtask
`endif

    initial begin
        reset_n = 0; btn_in = 0; en = 1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_en_gate();
        test_reset_mid();
        test_wrap();
        test_random();
`ifdef TOGGLE_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
